// File: rtl/branch_unit.sv
// branch_unit: program counter, conditional jump evaluation and a hardware
// call/return stack, sequenced by a RUN/HALT/FAULT state machine.
module branch_unit #(
  parameter int          UUID        = 0,
  parameter              NAME        = "",
  parameter int unsigned STACK_DEPTH = 8,
  parameter logic [7:0]  RESET_PC    = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   i_instruction,
  input  logic                         i_branch,
  input  logic                         i_stall,
  input  logic [7:0]                   i_target,
  input  logic                         i_cf,
  input  logic                         i_zf,
  input  logic                         i_sf,
  output logic [7:0]                   o_program_counter,
  output logic                         o_taken,
  output logic                         o_halted,
  output logic                         o_fault,
  output logic [$clog2(STACK_DEPTH):0] o_depth
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = AW + 1;

  localparam logic [1:0] OP_JMP  = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;
  localparam logic [1:0] OP_HLT  = 2'b11;

  // Reject unsupported stack depths and malformed instance identifiers at elaboration
  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 ||
      UUID < 0 || $bits(NAME) > 2048) begin : g_bad_params
    $error("branch_unit: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_pc;
  logic [DW-1:0] r_depth;
  logic          r_taken;
  logic          r_halted;
  logic          r_fault;
  logic [7:0]    r_stack [STACK_DEPTH];

  logic [1:0]    w_op;
  logic [2:0]    w_cc;
  logic          w_cond;
  logic          w_exec;
  logic          w_can_push;
  logic          w_can_pop;
  logic          w_push;
  logic [7:0]    w_pc_inc;
  logic [7:0]    w_top;
  logic          w_unused_instr;

  assign w_op           = i_instruction[4:3];
  assign w_cc           = i_instruction[2:0];
  assign w_unused_instr = ^i_instruction[7:5];
  assign w_pc_inc       = r_pc + 8'd1;
  assign w_can_push     = (r_depth < DW'(STACK_DEPTH));
  assign w_can_pop      = (r_depth != '0);
  assign w_top          = r_stack[AW'(r_depth - DW'(1))];

  // Evaluate the condition code against the flags sampled this cycle
  always_comb begin
    w_cond = 1'b0;
    case (w_cc)
      3'b000:  w_cond = 1'b1;
      3'b001:  w_cond = i_zf;
      3'b010:  w_cond = ~i_zf;
      3'b011:  w_cond = i_cf;
      3'b100:  w_cond = ~i_cf;
      3'b101:  w_cond = i_sf;
      3'b110:  w_cond = ~i_sf;
      default: w_cond = 1'b0;
    endcase
  end

  // A flow instruction acts only when running, not stalled, and its condition holds
  assign w_exec = (r_state == ST_RUN) && !i_stall && i_branch && w_cond;
  assign w_push = !rst && w_exec && (w_op == OP_CALL) && w_can_push;

  // Return-address storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[AW'(r_depth)] <= w_pc_inc;
    end
  end

  // Sequencing state machine with registered PC, depth and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_depth  <= '0;
      r_taken  <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_taken <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (!i_stall) begin
            if (!w_exec) begin
              r_pc <= w_pc_inc;
            end else begin
              case (w_op)
                OP_JMP: begin
                  r_pc    <= i_target;
                  r_taken <= 1'b1;
                end
                OP_CALL: begin
                  if (w_can_push) begin
                    r_pc    <= i_target;
                    r_depth <= r_depth + DW'(1);
                    r_taken <= 1'b1;
                  end else begin
                    r_state <= ST_FAULT;
                    r_fault <= 1'b1;
                  end
                end
                OP_RET: begin
                  if (w_can_pop) begin
                    r_pc    <= w_top;
                    r_depth <= r_depth - DW'(1);
                    r_taken <= 1'b1;
                  end else begin
                    r_state <= ST_FAULT;
                    r_fault <= 1'b1;
                  end
                end
                default: begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_HALT: begin
          r_halted <= 1'b1;
        end
        ST_FAULT: begin
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  assign o_program_counter = r_pc;
  assign o_taken           = r_taken;
  assign o_halted          = r_halted;
  assign o_fault           = r_fault;
  assign o_depth           = r_depth;

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Program-flow stage directly downstream of the 8-bit ALU.
- Consumes the ALU's registered CF/ZF/SF flags and the current instruction byte.
- Holds the 8-bit program counter, evaluates conditional jumps, and owns a hardware call/return stack.
- Drives the instruction-fetch address; sequencing is gated by a small run/halt/fault state machine.

Parameters:
- UUID, 0, instance identifier XORed into sub-component UUIDs.
- NAME, "", instance label.
- STACK_DEPTH, 8, return-stack entries; power of two, 2..16.
- RESET_PC, 8'h00, program counter value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Instruction  input  8  [4:3] op: 00 JMP, 01 CALL, 10 RET, 11 HLT. [2:0] condition code. [7:5] ignored.
- Branch?  input  1  Instruction is a flow instruction this cycle.
- Stall  input  1  freeze PC and stack this cycle.
- Target  input  8  jump/call destination.
- CF  input  1  carry flag from the ALU.
- ZF  input  1  zero flag from the ALU.
- SF  input  1  sign flag from the ALU.
- Program_Counter  output  8  registered fetch address.
- Taken  output  1  registered; 1 for one cycle after a taken JMP/CALL/RET.
- Halted  output  1  registered; state==HALT.
- Fault  output  1  registered; state==FAULT.
- Depth  output  clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: Program_Counter=RESET_PC, Depth=0, Taken=0, Halted=0, Fault=0, state=RUN. Stack contents are don't-care.
- Reset mid-operation: an asserted rst overrides every other input that cycle, in any state.
- Condition codes (cond true):
  - 000 always; 001 ZF; 010 !ZF; 011 CF; 100 !CF; 101 SF; 110 !SF; 111 never.
  - Flags are sampled in the same cycle as Branch?.
- FSM states: RUN, HALT, FAULT.
  - HALT and FAULT are absorbing; only rst exits them.
  - In HALT/FAULT: PC, stack and Depth hold; Taken=0.
- RUN, per cycle, in priority order:
  - Stall=1: everything holds, Taken<=0. Stall wins over Branch?.
  - Branch?=0, or cond false: PC<=PC+1, stack untouched, Taken<=0.
  - JMP: PC<=Target, Taken<=1.
  - CALL, Depth<STACK_DEPTH: push PC+1 (mod 256), Depth+1, PC<=Target, Taken<=1.
  - CALL, Depth==STACK_DEPTH: no push, PC holds, state<=FAULT, Taken<=0.
  - RET, Depth>0: PC<=top entry, Depth-1, Taken<=1.
  - RET, Depth==0: PC holds, state<=FAULT.
  - HLT: PC holds, state<=HALT.
- Arithmetic: PC increment wraps 255→0. A CALL at PC=255 pushes 0.
- Latency: one cycle. The new PC is visible on the edge after the decision; no combinational path from inputs to outputs.
- Stack: LIFO indexed by Depth. Push writes entry[Depth]; pop reads entry[Depth-1]. Only one push or pop per cycle.

Test Plan:
- Reset → PC=00, Depth=0, Halted=0, Fault=0. Run 300 cycles with Branch?=0 → PC wraps FF→00, Taken stays 0.
- JMP cond 001, ZF=0, Target=40, at PC=10 → PC=11, Taken=0. Repeat with ZF=1 → next PC=40, Taken=1 for one cycle.
- CALL always Target=80 at PC=05 → PC=80, Depth=1. RET always two cycles later → PC=06, Depth=0, Taken=1.
- Nine successive CALLs (STACK_DEPTH=8) → Depth stops at 8; ninth leaves PC unchanged, Fault=1. Further inputs ignored until rst.
- RET with Depth=0 → Fault=1, PC held. HLT cond 111 → no effect, PC+1. HLT cond 000 → Halted=1, PC frozen. Asserting rst in each case → all outputs return to reset values next edge.
- Stall=1 together with a taken CALL → PC, Depth unchanged, Taken=0. Deassert Stall with CALL still presented → call executes.
